// File: rtl/bu2020_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// bu2020_hazard_ctrl
// Pipeline control unit for the 5-stage BU2020 core (IF, ID, EX, MEM, WB).
//
// Purpose:
//   - Generates the PC and IF_ID write enables.
//   - Generates the per-stage bubble (flush) controls.
//   - Generates the taken-branch / jump PC redirect.
//   - Generates the EX operand-forwarding selects.
//   - Runs a RUN / DRAIN / HALTED state machine that empties the pipeline on
//     request.
//   - Keeps saturating stall and flush event counters.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_rs1/2, id_use_rs1/2     sources of the ID instruction and their use
//   ex_rs1/2, ex_rd            ID_EX sources and target
//   ex_regwrite, ex_memread    ID_EX RegWrite and load indication
//   mem_rd, mem_regwrite       EX_MEM target and RegWrite
//   wb_rd, wb_regwrite         MEM_WB target and RegWrite
//   mem_jump/bne/zero          EX_MEM branch controls
//   mem_target                 EX_MEM branch / jump target
//   halt_req / halt_ack        drain request, pipeline-frozen acknowledge
//   pc_we, pc_sel, pc_redirect PC control and redirect target
//   if_id_we                   IF_ID write enable
//   *_flush                    load a bubble into that stage register
//   fwd_a, fwd_b               00 regfile, 10 EX_MEM result, 01 MEM_WB data
//   stall_count, flush_count   saturating event counters
// ---------------------------------------------------------------------------
module bu2020_hazard_ctrl #(
  parameter int REG_AW       = 3,
  parameter int PC_W         = 16,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              mem_jump,
  input  logic              mem_bne,
  input  logic              mem_zero,
  input  logic [PC_W-1:0]   mem_target,
  input  logic              halt_req,
  output logic              halt_ack,
  output logic              pc_we,
  output logic              pc_sel,
  output logic [PC_W-1:0]   pc_redirect,
  output logic              if_id_we,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic taken_s;
  logic luse_s;
  logic stall_s;

  // Hazard detection: taken branch/jump in MEM and load-use between EX and ID
  always_comb begin
    taken_s = mem_jump | (mem_bne & ~mem_zero);
    luse_s  = ex_memread & ex_regwrite &
              ((id_use_rs1 & (id_rs1 == ex_rd)) |
               (id_use_rs2 & (id_rs2 == ex_rd)));
    // A taken branch flushes the load-use pair anyway, so it suppresses the stall
    stall_s = luse_s & ~taken_s;
  end

  // State register and drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      drain_q <= {DCW{1'b0}};
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic for the halt/drain sequencer
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_DRAIN;
          drain_d = DCW'(DRAIN_CYCLES);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end else if (!taken_s && !luse_s) begin
          // Only cycles that really advance the pipeline count toward empty
          drain_d = drain_q - DCW'(1);
          if (drain_q == DCW'(1)) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_RUN;
        drain_d = {DCW{1'b0}};
      end
    endcase
  end

  // Pipeline control outputs; reset, then taken, then load-use, then state
  always_comb begin
    halt_ack     = 1'b0;
    pc_we        = 1'b1;
    pc_sel       = 1'b0;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_redirect  = mem_target;

    case (state_q)
      ST_RUN: begin
        pc_we = 1'b1;
      end
      ST_DRAIN: begin
        // Stop fetching; bubbles enter IF_ID while older work drains
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
      end
      ST_HALTED: begin
        halt_ack    = 1'b1;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: begin
        pc_we = 1'b0;
      end
    endcase

    if (taken_s) begin
      pc_we        = 1'b1;
      pc_sel       = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (luse_s) begin
      // Hold PC and IF_ID, inject exactly one bubble into ID_EX
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      if (state_q != ST_HALTED) begin
        if_id_flush = 1'b0;
      end else begin
        if_id_flush = 1'b1;
      end
    end else begin
      pc_sel = 1'b0;
    end

    if (!rst_n) begin
      halt_ack     = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      halt_ack = halt_ack;
    end
  end

  // Operand forwarding; the younger EX_MEM result beats MEM_WB
  always_comb begin
    if (mem_regwrite && (mem_rd == ex_rs1)) begin
      fwd_a = 2'b10;
    end else if (wb_regwrite && (wb_rd == ex_rs1)) begin
      fwd_a = 2'b01;
    end else begin
      fwd_a = 2'b00;
    end
    if (mem_regwrite && (mem_rd == ex_rs2)) begin
      fwd_b = 2'b10;
    end else if (wb_regwrite && (wb_rd == ex_rs2)) begin
      fwd_b = 2'b01;
    end else begin
      fwd_b = 2'b00;
    end
  end

  // Saturating counter next values; they hold at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (taken_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_bu2020_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bu2020_hazard_ctrl
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model of the hazard rules.
// ---------------------------------------------------------------------------
module tb_bu2020_hazard_ctrl;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;
  localparam int CMAX    = 65535;

  logic        clk;
  logic        rst_n;
  logic [2:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
  logic        mem_regwrite, wb_regwrite, mem_jump, mem_bne, mem_zero;
  logic [15:0] mem_target;
  logic        halt_req;
  logic        halt_ack, pc_we, pc_sel, if_id_we;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic [15:0] pc_redirect, stall_count, flush_count;
  logic [1:0]  fwd_a, fwd_b;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_mode, m_rem, m_stall, m_flush;

  bu2020_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_jump(mem_jump), .mem_bne(mem_bne), .mem_zero(mem_zero),
    .mem_target(mem_target),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_redirect(pc_redirect),
    .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_taken();
    return mem_jump || (mem_bne && !mem_zero);
  endfunction

  function automatic bit is_luse();
    return ex_memread && ex_regwrite &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [1:0] fwd_of(input logic [2:0] rs);
    if (mem_regwrite && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd == rs)   return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_idle();
    id_rs1 = 3'd0; id_rs2 = 3'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = 3'd0; ex_rs2 = 3'd0; ex_rd = 3'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 3'd7; mem_regwrite = 1'b0; wb_rd = 3'd7; wb_regwrite = 1'b0;
    mem_jump = 1'b0; mem_bne = 1'b0; mem_zero = 1'b0; mem_target = 16'h0000;
    halt_req = 1'b0;
  endtask

  task automatic set_luse(input logic [2:0] rd);
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = rd;
    id_rs2 = rd; id_use_rs2 = 1'b1;
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_rem = 0; m_stall = 0; m_flush = 0;
  endtask

  // Compare all outputs against what the rules demand for the current cycle
  task automatic check_outputs();
    logic [6:0] e;
    logic       ha;
    ha = (m_mode == M_HALT);
    if (is_taken())      e = {ha, 6'b111111};
    else if (is_luse())  e = {ha, 1'b0, 1'b0, 1'b0, ha, 1'b1, 1'b0};
    else if (m_mode == M_RUN)   e = 7'b0101000;
    else if (m_mode == M_DRAIN) e = 7'b0001100;
    else                        e = 7'b1000110;
    chk_val("ctl{ack,we,sel,ifwe,fl3}",
            {25'd0, halt_ack, pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush},
            {25'd0, e});
    chk_val("fwd_a", {30'd0, fwd_a}, {30'd0, fwd_of(ex_rs1)});
    chk_val("fwd_b", {30'd0, fwd_b}, {30'd0, fwd_of(ex_rs2)});
    if (is_taken()) chk_val("pc_redirect", {16'd0, pc_redirect}, {16'd0, mem_target});
    chk_val("stall_count", {16'd0, stall_count}, m_stall);
    chk_val("flush_count", {16'd0, flush_count}, m_flush);
  endtask

  // Advance the model over one clock edge with the current inputs
  task automatic model_update();
    bit tk, lu;
    tk = is_taken();
    lu = is_luse();
    if (tk) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    else if (lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    case (m_mode)
      M_RUN: if (halt_req) begin m_mode = M_DRAIN; m_rem = 4; end
      M_DRAIN: begin
        if (!halt_req) m_mode = M_RUN;
        else if (!tk && !lu) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_mode = M_HALT;
        end
      end
      default: if (!halt_req) m_mode = M_RUN;
    endcase
  endtask

  // Called at posedge+1 with inputs set; checks, then crosses the next edge
  task automatic run_cycle(input bit do_chk);
    #3;
    if (do_chk) check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    chk_val("rst_ctl{ack,we,sel,ifwe,fl3}",
            {25'd0, halt_ack, pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush},
            {25'd0, 7'b0000111});
    chk_val("rst_stall_count", {16'd0, stall_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_inputs();
    id_rs1 = 3'($urandom_range(0, 3)); id_rs2 = 3'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
    ex_rs1 = 3'($urandom_range(0, 3)); ex_rs2 = 3'($urandom_range(0, 3));
    ex_rd = 3'($urandom_range(0, 3));
    ex_regwrite = 1'($urandom_range(0, 1)); ex_memread = ($urandom_range(0, 2) == 0);
    mem_rd = 3'($urandom_range(0, 3)); mem_regwrite = 1'($urandom_range(0, 1));
    wb_rd = 3'($urandom_range(0, 3)); wb_regwrite = 1'($urandom_range(0, 1));
    mem_jump = ($urandom_range(0, 15) == 0);
    mem_bne = ($urandom_range(0, 5) == 0); mem_zero = 1'($urandom_range(0, 1));
    mem_target = 16'($urandom);
    if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
  endtask

  initial begin
    int drain_n;
    set_idle();
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    apply_reset();

    // Reset asserted while DRAIN is active
    halt_req = 1'b1;
    run_cycle(1'b1);
    mem_jump = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_val("rst_in_drain{ack,we,sel,ifwe,fl3}",
            {25'd0, halt_ack, pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush},
            {25'd0, 7'b0000111});
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    set_idle();
    #2;
    chk_val("post_rst_pc_we", {31'd0, pc_we}, 32'd1);
    chk_val("post_rst_stall_count", {16'd0, stall_count}, 32'd0);
    run_cycle(1'b1);

    // Load-use on rs2 = x3, then the load moves through MEM and WB
    set_luse(3'd3);
    run_cycle(1'b1);
    set_idle();
    mem_rd = 3'd3; mem_regwrite = 1'b1; ex_rs2 = 3'd3;
    run_cycle(1'b1);
    set_idle();
    wb_rd = 3'd3; wb_regwrite = 1'b1; ex_rs2 = 3'd3;
    #2;
    chk_val("luse_fwd_b_wb", {30'd0, fwd_b}, 32'd1);
    chk_val("luse_stall_count", {16'd0, stall_count}, 32'd1);
    run_cycle(1'b1);

    // Taken BNE together with a load-use: branch wins
    set_idle();
    set_luse(3'd2);
    mem_bne = 1'b1; mem_zero = 1'b0; mem_target = 16'h0040;
    #2;
    chk_val("br_pc_sel", {31'd0, pc_sel}, 32'd1);
    chk_val("br_redirect", {16'd0, pc_redirect}, 32'h40);
    run_cycle(1'b1);
    chk_val("br_flush_count", {16'd0, flush_count}, 32'd1);
    chk_val("br_stall_count", {16'd0, stall_count}, 32'd1);
    mem_zero = 1'b1;
    #2;
    chk_val("bne_not_taken_pc_sel", {31'd0, pc_sel}, 32'd0);
    run_cycle(1'b1);

    // Forwarding priority
    set_idle();
    mem_rd = 3'd5; wb_rd = 3'd5; ex_rs1 = 3'd5;
    mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    #2;
    chk_val("fwd_prio_mem", {30'd0, fwd_a}, 32'd2);
    mem_regwrite = 1'b0;
    #1;
    chk_val("fwd_prio_wb", {30'd0, fwd_a}, 32'd1);
    run_cycle(1'b1);

    // Halt with no hazards: four drain cycles, then acknowledge
    set_idle();
    apply_reset();
    halt_req = 1'b1;
    drain_n = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (!halt_ack && !pc_we) drain_n++;
      run_cycle(1'b1);
    end
    chk_val("halt_drain_cycles", drain_n, 32'd4);
    chk_val("halt_ack_set", {31'd0, halt_ack}, 32'd1);
    halt_req = 1'b0;
    run_cycle(1'b1);
    #2;
    chk_val("resume_halt_ack", {31'd0, halt_ack}, 32'd0);
    chk_val("resume_pc_we", {31'd0, pc_we}, 32'd1);
    run_cycle(1'b1);

    // Halt with a load-use stall in the second drain cycle
    set_idle();
    apply_reset();
    halt_req = 1'b1;
    drain_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) set_luse(3'd4);
      else begin ex_memread = 1'b0; ex_regwrite = 1'b0; end
      #2;
      if (!halt_ack && !pc_we) drain_n++;
      run_cycle(1'b1);
    end
    chk_val("halt_drain_stall_cycles", drain_n, 32'd5);
    chk_val("halt_stall_ack", {31'd0, halt_ack}, 32'd1);

    // Randomized traffic against the model
    set_idle();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      run_cycle(1'b1);
    end

    // Stall counter saturation
    set_idle();
    apply_reset();
    set_luse(3'd1);
    for (int i = 0; i < 65539; i++) begin
      run_cycle((i % 8192) == 0);
    end
    #2;
    chk_val("stall_saturate", {16'd0, stall_count}, 32'h0000FFFF);
    run_cycle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
